dispatch_ctrl_alu: RTL and testbench

- Dispatch-side scheduler for the ALU issue unit. It sits between rename/dispatch and issue_unit_ALU.
- Accepts up to two renamed ALU uops per cycle and holds them in a small in-order buffer.
- Each cycle, drives enq_req_0/enq_req_1 into the issue unit according to that unit's ready.
- Always compacts, so slot 0 is used before slot 1; handles flush; exposes occupancy and a stall counter.

---
 rtl/dispatch_ctrl_alu_pkg.sv | 23 ++
 rtl/dispatch_ctrl_alu_dual_port_fifo2.sv | 71 +++++++
 rtl/dispatch_ctrl_alu.sv | 81 ++++++++
 tb/tb_dispatch_ctrl_alu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_alu_pkg.sv
// Shared dispatch/issue types: the ALU queue payload, the two-wide uop bundle
// and the dispatch buffer depth.
package dispatch_ctrl_alu_pkg;

    localparam int DISPATCH_BUF_DEPTH = 4;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [3:0]  alu_op;
        logic [6:0]  pdst;
        logic [6:0]  psrc1;
        logic [6:0]  psrc2;
        logic [16:0] imm;
    } ALU_Queue_Meta;

    typedef struct packed {
        logic          valid_0;
        logic          valid_1;
        ALU_Queue_Meta uop_0;
        ALU_Queue_Meta uop_1;
    } UOPBundle;

endpackage

// File: rtl/dispatch_ctrl_alu_dual_port_fifo2.sv
// Two-push/two-pop circular buffer with occupancy count; reads are combinational from head.
// Latency: a write is readable the cycle after; no backpressure of its own, the caller gates wr/rd by count.
module dual_port_fifo2
    import dispatch_ctrl_alu_pkg::*;
#(
    parameter int DEPTH = DISPATCH_BUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en_0,
    input  logic             wr_en_1,
    input  ALU_Queue_Meta    wr_dat_0,
    input  ALU_Queue_Meta    wr_dat_1,
    input  logic [1:0]       rd_num,
    output ALU_Queue_Meta    rd_dat_0,
    output ALU_Queue_Meta    rd_dat_1,
    output logic [OCC_W-1:0] count
);

    ALU_Queue_Meta    r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_count;
    logic [PTR_W-1:0] w_head_1;
    logic [PTR_W-1:0] w_tail_1;
    logic [1:0]       w_wr_num;

    assign w_wr_num = {1'b0, wr_en_0} + {1'b0, wr_en_1};
    assign w_head_1 = r_head + PTR_W'(1);
    assign w_tail_1 = r_tail + PTR_W'(1);

    // wr_en_1 is only ever set together with wr_en_0, so port 1 lands at tail+1.
    always_ff @(posedge clk) begin
        if (wr_en_0) r_mem[r_tail]   <= wr_dat_0;
        if (wr_en_1) r_mem[w_tail_1] <= wr_dat_1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(rd_num);
            r_tail  <= r_tail + PTR_W'(w_wr_num);
            r_count <= r_count + OCC_W'(w_wr_num) - OCC_W'(rd_num);
        end
    end

    assign rd_dat_0 = r_mem[r_head];
    assign rd_dat_1 = r_mem[w_head_1];
    assign count    = r_count;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && !clr) begin
            assert (int'(r_count) <= DEPTH);
            assert (int'(w_wr_num) <= DEPTH - int'(r_count));
            assert (int'(rd_num) <= int'(r_count));
        end
    end
`endif

endmodule

// File: rtl/dispatch_ctrl_alu.sv
// Dispatch-side in-order buffer feeding issue_unit_ALU two uops per cycle, with flush and stall counter.
// Latency: 1 cycle accept->enq, no bypass; in_ready needs two free entries, judged on registered count only.
module dispatch_ctrl_alu
    import dispatch_ctrl_alu_pkg::*;
#(
    parameter int BUF_DEPTH = DISPATCH_BUF_DEPTH,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid_0,
    input  logic                           in_valid_1,
    input  ALU_Queue_Meta                  in_uop_0,
    input  ALU_Queue_Meta                  in_uop_1,
    output logic                           in_ready,
    input  logic                           iq_ready,
    output logic                           enq_req_0,
    output logic                           enq_req_1,
    output ALU_Queue_Meta                  enq_ops_0,
    output ALU_Queue_Meta                  enq_ops_1,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]               stall_cnt
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [OCC_W-1:0] w_count;
    logic             w_accept;
    logic             w_wr_en_0;
    logic             w_wr_en_1;
    logic [1:0]       w_rd_num;
    ALU_Queue_Meta    w_wr_dat_0;
    ALU_Queue_Meta    w_rd_dat_0;
    ALU_Queue_Meta    w_rd_dat_1;
    logic [CNT_W-1:0] r_stall_cnt;

    assign in_ready = (w_count <= OCC_W'(BUF_DEPTH - 2));
    assign w_accept = in_ready & ~flush;

    // Compaction: a lone slot-1 uop takes write port 0 so the buffer never has holes.
    assign w_wr_en_0  = w_accept & (in_valid_0 | in_valid_1);
    assign w_wr_en_1  = w_accept & in_valid_0 & in_valid_1;
    assign w_wr_dat_0 = in_valid_0 ? in_uop_0 : in_uop_1;

    assign enq_req_0 = iq_ready & (w_count != '0) & ~flush;
    assign enq_req_1 = iq_ready & (w_count >= OCC_W'(2)) & ~flush;
    assign w_rd_num  = {1'b0, enq_req_0} + {1'b0, enq_req_1};

    dual_port_fifo2 #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .wr_en_0  (w_wr_en_0),
        .wr_en_1  (w_wr_en_1),
        .wr_dat_0 (w_wr_dat_0),
        .wr_dat_1 (in_uop_1),
        .rd_num   (w_rd_num),
        .rd_dat_0 (w_rd_dat_0),
        .rd_dat_1 (w_rd_dat_1),
        .count    (w_count)
    );

    // Storage is not reset, so the payload is forced to zero while reset is held.
    assign enq_ops_0 = rst ? '0 : w_rd_dat_0;
    assign enq_ops_1 = rst ? '0 : w_rd_dat_1;
    assign occupancy = w_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((w_count != '0) && !iq_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_ctrl_alu.sv
// Scoreboard bench: driver pushes accepted uops into an expected FIFO, monitor pops/compares on enq.
module tb_dispatch_ctrl_alu;
    import dispatch_ctrl_alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int SW    = 4;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int SMAX  = (1 << SW) - 1;

    logic          clk = 0;
    logic          rst = 0;
    logic          flush = 0;
    logic          in_valid_0 = 0;
    logic          in_valid_1 = 0;
    logic          iq_ready = 0;
    ALU_Queue_Meta in_uop_0 = '0;
    ALU_Queue_Meta in_uop_1 = '0;
    logic          in_ready;
    logic          enq_req_0;
    logic          enq_req_1;
    ALU_Queue_Meta enq_ops_0;
    ALU_Queue_Meta enq_ops_1;
    logic [OW-1:0] occupancy;
    logic [SW-1:0] stall_cnt;

    ALU_Queue_Meta exp_q[$];
    int            exp_stall = 0;
    int            checks = 0;
    int            errors = 0;
    int            seq = 0;
    logic          last_acc = 1;
    logic          last_fl = 0;

    dispatch_ctrl_alu #(.BUF_DEPTH(DEPTH), .CNT_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid_0 (in_valid_0),
        .in_valid_1 (in_valid_1),
        .in_uop_0   (in_uop_0),
        .in_uop_1   (in_uop_1),
        .in_ready   (in_ready),
        .iq_ready   (iq_ready),
        .enq_req_0  (enq_req_0),
        .enq_req_1  (enq_req_1),
        .enq_ops_0  (enq_ops_0),
        .enq_ops_1  (enq_ops_1),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic ALU_Queue_Meta mk(input int s);
        ALU_Queue_Meta u;
        u.rob_idx = 6'($urandom);
        u.alu_op  = 4'($urandom);
        u.pdst    = 7'($urandom);
        u.psrc1   = 7'($urandom);
        u.psrc2   = 7'($urandom);
        u.imm     = 17'(s);
        return u;
    endfunction

    // Monitor: expectations come from the queue contents and the interface rules only.
    initial begin : monitor
        int   sz;
        logic e0;
        logic e1;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                exp_q.delete();
                exp_stall = 0;
                chk("rst_in_ready", 64'(in_ready), 64'(1));
                chk("rst_enq_req_0", 64'(enq_req_0), 64'(0));
                chk("rst_enq_req_1", 64'(enq_req_1), 64'(0));
                chk("rst_enq_ops_0", 64'(enq_ops_0), 64'(0));
                chk("rst_enq_ops_1", 64'(enq_ops_1), 64'(0));
                chk("rst_occupancy", 64'(occupancy), 64'(0));
                chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
            end else begin
                sz = exp_q.size();
                e0 = iq_ready && (sz >= 1) && !flush;
                e1 = iq_ready && (sz >= 2) && !flush;
                chk("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= 2));
                chk("occupancy", 64'(occupancy), 64'(sz));
                chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
                chk("enq_req_0", 64'(enq_req_0), 64'(e0));
                chk("enq_req_1", 64'(enq_req_1), 64'(e1));
                if (e0) chk("enq_ops_0", 64'(enq_ops_0), 64'(exp_q[0]));
                if (e1) chk("enq_ops_1", 64'(enq_ops_1), 64'(exp_q[1]));
                if ((sz >= 1) && !iq_ready && !flush && (exp_stall < SMAX)) exp_stall++;
                if (e0) void'(exp_q.pop_front());
                if (e1) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; accepted uops enter the expected queue after the monitor has sampled.
    task automatic drive(input logic v0, input logic v1, input ALU_Queue_Meta u0,
                         input ALU_Queue_Meta u1, input logic iq, input logic fl);
        logic acc;
        @(posedge clk);
        #1;
        in_valid_0 = v0;
        in_valid_1 = v1;
        in_uop_0   = u0;
        in_uop_1   = u1;
        iq_ready   = iq;
        flush      = fl;
        acc        = ((DEPTH - exp_q.size()) >= 2) && !fl;
        last_acc   = acc;
        last_fl    = fl;
        @(negedge clk);
        #2;
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            if (v0) exp_q.push_back(u0);
            if (v1) exp_q.push_back(u1);
        end
    endtask

    task automatic idle(input logic iq);
        drive(1'b0, 1'b0, '0, '0, iq, 1'b0);
    endtask

    // Called straight after drive(): rst rises mid-cycle, before the next clock edge.
    task automatic mid_reset();
        #1;
        rst        = 1;
        in_valid_0 = 0;
        in_valid_1 = 0;
        flush      = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        ALU_Queue_Meta a, b, c, d, e, f;
        ALU_Queue_Meta r0, r1;
        logic rv0, rv1, riq, rfl;

        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Dual push, drained as a pair the next cycle.
        a = mk(seq++); b = mk(seq++);
        drive(1, 1, a, b, 1, 0);
        idle(1);
        idle(1);

        // Slot-1-only uop compacts into enq slot 0.
        c = mk(seq++);
        drive(0, 1, '0, c, 1, 0);
        idle(1);
        idle(1);

        // Backpressure: fill to 4, third pair held until two entries free.
        a = mk(seq++); b = mk(seq++); c = mk(seq++);
        d = mk(seq++); e = mk(seq++); f = mk(seq++);
        drive(1, 1, a, b, 0, 0);
        drive(1, 1, c, d, 0, 0);
        drive(1, 1, e, f, 0, 0);
        drive(1, 1, e, f, 1, 0);
        drive(1, 1, e, f, 1, 0);
        idle(1);
        idle(1);

        // Steady 2-in/2-out across pointer wrap.
        repeat (10) begin
            a = mk(seq++); b = mk(seq++);
            drive(1, 1, a, b, 1, 0);
        end
        idle(1);
        idle(1);

        // Flush at occupancy 3 with a valid pair presented.
        a = mk(seq++); b = mk(seq++); c = mk(seq++);
        drive(1, 1, a, b, 0, 0);
        drive(0, 1, '0, c, 0, 0);
        d = mk(seq++); e = mk(seq++);
        drive(1, 1, d, e, 1, 1);
        idle(0);
        idle(1);

        // Random traffic with held inputs on refusal, flushes and one mid-run reset.
        rv0 = 0; rv1 = 0; r0 = '0; r1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (last_acc || last_fl || !(rv0 || rv1)) begin
                rv0 = 1'($urandom);
                rv1 = 1'($urandom);
                r0  = mk(seq++);
                r1  = mk(seq++);
            end
            riq = ($urandom_range(0, 9) < 6);
            rfl = ($urandom_range(0, 24) == 0);
            drive(rv0, rv1, r0, r1, riq, rfl);
            if (i == 200) mid_reset();
        end
        repeat (4) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
